// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode map, forwarding-source encoding and
// the per-opcode source-register usage decode.
package pipe_pkg;

  localparam logic [3:0] OP_RTYPE0 = 4'h0;
  localparam logic [3:0] OP_RTYPE1 = 4'h1;
  localparam logic [3:0] OP_RTYPE2 = 4'h2;
  localparam logic [3:0] OP_ADDI   = 4'h3;
  localparam logic [3:0] OP_ANDI   = 4'h4;
  localparam logic [3:0] OP_LW     = 4'h5;
  localparam logic [3:0] OP_SW     = 4'h6;
  localparam logic [3:0] OP_BEQ    = 4'h7;
  localparam logic [3:0] OP_BNE    = 4'h8;
  localparam logic [3:0] OP_BLT    = 4'h9;
  localparam logic [3:0] OP_J      = 4'hA;
  localparam logic [3:0] OP_CALL   = 4'hB;
  localparam logic [3:0] OP_RET    = 4'hC;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // Returns {use1, use2}: whether the opcode reads RS1 / RS2.
  function automatic logic [1:0] src_use(input logic [3:0] opcode);
    logic [1:0] u;
    u = 2'b00;
    if (opcode <= OP_RTYPE2)
      u = 2'b11;
    else if (opcode <= OP_LW)
      u = 2'b10;
    else if (opcode <= OP_BLT)
      u = 2'b11;
    return u;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding source select; the youngest writing stage that
// targets the source register wins, and R0 never forwards.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = 3
) (
  input  logic [REG_W-1:0] rs,
  input  logic             use_src,
  input  logic [REG_W-1:0] Rd2,
  input  logic [REG_W-1:0] Rd3,
  input  logic [REG_W-1:0] Rd4,
  input  logic             EX_RegWr,
  input  logic             MEM_RegWr,
  input  logic             WB_RegWr,
  output logic [1:0]       sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_RF;
    if (use_src && (rs != '0)) begin
      if (EX_RegWr && (Rd2 == rs))
        sel_e = FWD_EX;
      else if (MEM_RegWr && (Rd3 == rs))
        sel_e = FWD_MEM;
      else if (WB_RegWr && (Rd4 == rs))
        sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard unit: operand forwarding selects and a one-cycle
// load-use stall for the 5-stage 16-bit pipeline.
module hazard_detect_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W    = 3,
  parameter int unsigned OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic [REG_W-1:0]    RS1,
  input  logic [REG_W-1:0]    RS2,
  input  logic [REG_W-1:0]    Rd2,
  input  logic [REG_W-1:0]    Rd3,
  input  logic [REG_W-1:0]    Rd4,
  input  logic                EX_RegWr,
  input  logic                MEM_RegWr,
  input  logic                WB_RegWr,
  input  logic                EX_MemRd,
  output logic                stall,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB
);

  logic [1:0] uses;
  logic       use1;
  logic       use2;
  logic       hazard;
  logic       stall_q;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign uses = src_use(opCode);
  assign use1 = uses[1];
  assign use2 = uses[0];

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .rs        (RS1),
    .use_src   (use1),
    .Rd2       (Rd2),
    .Rd3       (Rd3),
    .Rd4       (Rd4),
    .EX_RegWr  (EX_RegWr),
    .MEM_RegWr (MEM_RegWr),
    .WB_RegWr  (WB_RegWr),
    .sel       (fwd_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .rs        (RS2),
    .use_src   (use2),
    .Rd2       (Rd2),
    .Rd3       (Rd3),
    .Rd4       (Rd4),
    .EX_RegWr  (EX_RegWr),
    .MEM_RegWr (MEM_RegWr),
    .WB_RegWr  (WB_RegWr),
    .sel       (fwd_b)
  );

  always_comb begin
    hazard = 1'b0;
    if (EX_MemRd && EX_RegWr && (Rd2 != '0))
      hazard = (use1 && (Rd2 == RS1)) || (use2 && (Rd2 == RS2));
  end

  // stall_q masks the cycle after a stall so held inputs cannot lock up the pipe.
  assign stall    = rst_n && hazard && !stall_q;
  assign ForwardA = rst_n ? fwd_a : FWD_RF;
  assign ForwardB = rst_n ? fwd_b : FWD_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 1'b0;
    else
      stall_q <= stall;
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed testbench for hazard_detect_unit with hand-computed expectations.
module tb_hazard_detect_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opCode;
  logic [2:0] RS1, RS2, Rd2, Rd3, Rd4;
  logic       EX_RegWr, MEM_RegWr, WB_RegWr, EX_MemRd;
  logic       stall;
  logic [1:0] ForwardA, ForwardB;

  int checks;
  int failures;

  hazard_detect_unit #(.REG_W(3), .OPCODE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opCode    (opCode),
    .RS1       (RS1),
    .RS2       (RS2),
    .Rd2       (Rd2),
    .Rd3       (Rd3),
    .Rd4       (Rd4),
    .EX_RegWr  (EX_RegWr),
    .MEM_RegWr (MEM_RegWr),
    .WB_RegWr  (WB_RegWr),
    .EX_MemRd  (EX_MemRd),
    .stall     (stall),
    .ForwardA  (ForwardA),
    .ForwardB  (ForwardB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] d2, input logic [2:0] d3, input logic [2:0] d4,
                       input logic exw, input logic memw, input logic wbw, input logic exrd);
    opCode = op; RS1 = r1; RS2 = r2; Rd2 = d2; Rd3 = d3; Rd4 = d4;
    EX_RegWr = exw; MEM_RegWr = memw; WB_RegWr = wbw; EX_MemRd = exrd;
  endtask

  // Quiet inputs for one clock so stall_q is known to be 0 afterwards.
  task automatic settle();
    drive(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'h0, 3'd3, 3'd4, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%b expected=0", stall); end
    checks++; if (ForwardA !== 2'b00) begin failures++; $display("FAIL reset_fwdA actual=%b expected=00", ForwardA); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL reset_fwdB actual=%b expected=00", ForwardB); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_clk actual=%b expected=0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL release_stall actual=%b expected=1", stall); end
    checks++; if (ForwardA !== 2'b01) begin failures++; $display("FAIL release_fwdA actual=%b expected=01", ForwardA); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL release_fwdB actual=%b expected=00", ForwardB); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL release_stall_once actual=%b expected=0", stall); end
    @(negedge clk);
    settle();
  endtask

  task automatic test_priority();
    drive(4'h0, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (ForwardA !== 2'b01) begin failures++; $display("FAIL prio_ex actual=%b expected=01", ForwardA); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL prio_b_r0 actual=%b expected=00", ForwardB); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL prio_nostall actual=%b expected=0", stall); end
    EX_RegWr = 1'b0; #1;
    checks++; if (ForwardA !== 2'b10) begin failures++; $display("FAIL prio_mem actual=%b expected=10", ForwardA); end
    MEM_RegWr = 1'b0; #1;
    checks++; if (ForwardA !== 2'b11) begin failures++; $display("FAIL prio_wb actual=%b expected=11", ForwardA); end
    WB_RegWr = 1'b0; #1;
    checks++; if (ForwardA !== 2'b00) begin failures++; $display("FAIL nonwriting_rf actual=%b expected=00", ForwardA); end
    settle();
  endtask

  task automatic test_operand_b();
    drive(4'h0, 3'd1, 3'd5, 3'd0, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (ForwardB !== 2'b10) begin failures++; $display("FAIL opb_mem actual=%b expected=10", ForwardB); end
    checks++; if (ForwardA !== 2'b00) begin failures++; $display("FAIL opb_a_rf actual=%b expected=00", ForwardA); end
    drive(4'h9, 3'd1, 3'd6, 3'd2, 3'd2, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (ForwardB !== 2'b11) begin failures++; $display("FAIL branch_b_wb actual=%b expected=11", ForwardB); end
    settle();
  endtask

  task automatic test_load_use();
    drive(4'h0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall actual=%b expected=1", stall); end
    checks++; if (ForwardB !== 2'b01) begin failures++; $display("FAIL lu_fwdB_during actual=%b expected=01", ForwardB); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_held_release actual=%b expected=0", stall); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_held_restall actual=%b expected=1", stall); end
    @(negedge clk);
    drive(4'h0, 3'd1, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (ForwardB !== 2'b10) begin failures++; $display("FAIL lu_after_mem actual=%b expected=10", ForwardB); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_after_nostall actual=%b expected=0", stall); end
    settle();
    // Both operands hit the same load: one stall, then released.
    drive(4'h1, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL dual_stall actual=%b expected=1", stall); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dual_release actual=%b expected=0", stall); end
    @(negedge clk);
    settle();
  endtask

  task automatic test_r0_and_unused();
    drive(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (ForwardA !== 2'b00) begin failures++; $display("FAIL r0_fwdA actual=%b expected=00", ForwardA); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall actual=%b expected=0", stall); end
    drive(4'h3, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL imm_rs2_unused actual=%b expected=0", stall); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL imm_fwdB actual=%b expected=00", ForwardB); end
    drive(4'h5, 3'd2, 3'd7, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_rs1_stall actual=%b expected=1", stall); end
    settle();
    drive(4'h6, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sw_rs2_stall actual=%b expected=1", stall); end
    settle();
  endtask

  task automatic test_no_source();
    drive(4'hA, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nosrc_stall actual=%b expected=0", stall); end
    checks++; if (ForwardA !== 2'b00) begin failures++; $display("FAIL nosrc_fwdA actual=%b expected=00", ForwardA); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL nosrc_fwdB actual=%b expected=00", ForwardB); end
    opCode = 4'hF; #1;
    checks++; if ({stall, ForwardA, ForwardB} !== 5'b0) begin failures++; $display("FAIL unused_op actual=%b expected=00000", {stall, ForwardA, ForwardB}); end
    settle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    @(negedge clk);
    test_reset();
    test_priority();
    test_operand_b();
    test_load_use();
    test_r0_and_unused();
    test_no_source();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
